// File: rtl/dataslot_cmd_sequencer.sv
// ============================================================================
// Module   : dataslot_cmd_sequencer
// Purpose  : Round-robin sharing of the single target-dataslot command port
//            among NUM_REQ core-side requesters. Optional ack/done timeout is
//            built when DATASLOT_SEQ_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataslot_cmd_sequencer #(
    parameter int NUM_REQ     = 2,
    parameter int ACK_TIMEOUT = 1048576
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*16-1:0] req_id,
    input  logic [NUM_REQ*32-1:0] req_slotoffset,
    input  logic [NUM_REQ*32-1:0] req_bridgeaddr,
    input  logic [NUM_REQ*32-1:0] req_length,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_done,
    output logic [2:0]            resp_err,
    output logic                  busy,
    output logic                  target_dataslot_read,
    output logic                  target_dataslot_write,
    output logic [15:0]           target_dataslot_id,
    output logic [31:0]           target_dataslot_slotoffset,
    output logic [31:0]           target_dataslot_bridgeaddr,
    output logic [31:0]           target_dataslot_length,
    input  logic                  target_dataslot_ack,
    input  logic                  target_dataslot_done,
    input  logic [2:0]            target_dataslot_err
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_RESP      = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;

    logic [PW-1:0] r_rr;
    logic [PW-1:0] r_gnt;
    logic [PW-1:0] w_gnt_idx;
    logic          w_gnt_found;
    int            w_scan;

    logic          w_sel_write;
    logic [15:0]   w_sel_id;
    logic [31:0]   w_sel_off;
    logic [31:0]   w_sel_addr;
    logic [31:0]   w_sel_len;

    logic          r_write;
    logic [15:0]   r_id;
    logic [31:0]   r_off;
    logic [31:0]   r_addr;
    logic [31:0]   r_len;
    logic [2:0]    r_err;

    logic          w_timeout;

    // Round-robin pick: first valid lane at or after the pointer, wrapping.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!w_gnt_found && (i == w_scan) && req_valid[i]) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = PW'(i);
                end
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_id    = '0;
        w_sel_off   = '0;
        w_sel_addr  = '0;
        w_sel_len   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == PW'(i)) begin
                w_sel_write = req_write[i];
                w_sel_id    = req_id[16*i +: 16];
                w_sel_off   = req_slotoffset[32*i +: 32];
                w_sel_addr  = req_bridgeaddr[32*i +: 32];
                w_sel_len   = req_length[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_gnt   <= '0;
            r_write <= 1'b0;
            r_id    <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_gnt   <= w_gnt_idx;
                r_write <= w_sel_write;
                r_id    <= w_sel_id;
                r_off   <= w_sel_off;
                r_addr  <= w_sel_addr;
                r_len   <= w_sel_len;
            end
            if (r_state == S_WAIT_DONE && target_dataslot_done) begin
                r_err <= target_dataslot_err;
            end else if (w_timeout && w_state_next == S_RESP) begin
                r_err <= 3'h7;
            end
            if (r_state == S_RESP) begin
                r_rr <= (r_gnt == PW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
            end
        end
    end

    // Done arriving in ISSUE is stale from a previous command and is ignored.
    always_comb begin
        w_state_next          = r_state;
        w_accept              = 1'b0;
        req_ready             = '0;
        resp_done             = '0;
        resp_err              = 3'h0;
        busy                  = 1'b0;
        target_dataslot_read  = 1'b0;
        target_dataslot_write = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                busy                  = 1'b1;
                target_dataslot_read  = !r_write;
                target_dataslot_write = r_write;
                if (target_dataslot_ack) begin
                    w_state_next = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_WAIT_DONE: begin
                busy = 1'b1;
                if (target_dataslot_done || w_timeout) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                busy         = 1'b1;
                w_state_next = S_GAP;
            end
            S_GAP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // A reset cycle must never report an accept or a completion.
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = w_accept && !reset && (w_gnt_idx == PW'(i));
            resp_done[i] = (r_state == S_RESP) && !reset && (r_gnt == PW'(i));
        end
        if (r_state == S_RESP && !reset) begin
            resp_err = r_err;
        end
    end

`ifdef DATASLOT_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    logic [CW-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == S_ISSUE || r_state == S_WAIT_DONE) && !w_timeout) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_ISSUE || r_state == S_WAIT_DONE) &&
                       (r_tmo_cnt >= CW'(ACK_TIMEOUT - 1));
`else
    // No counter: the comparison is constant false for any legal ACK_TIMEOUT.
    assign w_timeout = (ACK_TIMEOUT < 0);
`endif

    assign target_dataslot_id         = r_id;
    assign target_dataslot_slotoffset = r_off;
    assign target_dataslot_bridgeaddr = r_addr;
    assign target_dataslot_length     = r_len;

endmodule

`default_nettype wire

// File: tb/tb_dataslot_cmd_sequencer.sv
// ============================================================================
// Module   : tb_dataslot_cmd_sequencer
// Purpose  : Directed and randomized checks of dataslot_cmd_sequencer against
//            a transaction-level round-robin model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dataslot_cmd_sequencer;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*16-1:0] req_id;
    logic [N*32-1:0] req_slotoffset;
    logic [N*32-1:0] req_bridgeaddr;
    logic [N*32-1:0] req_length;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_done;
    logic [2:0]      resp_err;
    logic            busy;
    logic            target_dataslot_read;
    logic            target_dataslot_write;
    logic [15:0]     target_dataslot_id;
    logic [31:0]     target_dataslot_slotoffset;
    logic [31:0]     target_dataslot_bridgeaddr;
    logic [31:0]     target_dataslot_length;
    logic            target_dataslot_ack;
    logic            target_dataslot_done;
    logic [2:0]      target_dataslot_err;

    int n_vec = 0;
    int n_err = 0;
    int m_rr  = 0;

    always #5 clk = ~clk;

    dataslot_cmd_sequencer #(
        .NUM_REQ     (N),
        .ACK_TIMEOUT (1048576)
    ) dut (
        .clk                        (clk),
        .reset                      (reset),
        .req_valid                  (req_valid),
        .req_write                  (req_write),
        .req_id                     (req_id),
        .req_slotoffset             (req_slotoffset),
        .req_bridgeaddr             (req_bridgeaddr),
        .req_length                 (req_length),
        .req_ready                  (req_ready),
        .resp_done                  (resp_done),
        .resp_err                   (resp_err),
        .busy                       (busy),
        .target_dataslot_read       (target_dataslot_read),
        .target_dataslot_write      (target_dataslot_write),
        .target_dataslot_id         (target_dataslot_id),
        .target_dataslot_slotoffset (target_dataslot_slotoffset),
        .target_dataslot_bridgeaddr (target_dataslot_bridgeaddr),
        .target_dataslot_length     (target_dataslot_length),
        .target_dataslot_ack        (target_dataslot_ack),
        .target_dataslot_done       (target_dataslot_done),
        .target_dataslot_err        (target_dataslot_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_lane(input int i, input bit wr);
        req_valid[i]               = 1'b1;
        req_write[i]               = wr;
        req_id[16*i +: 16]         = 16'($urandom);
        req_slotoffset[32*i +: 32] = $urandom;
        req_bridgeaddr[32*i +: 32] = $urandom;
        req_length[32*i +: 32]     = $urandom;
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    // One full command from the idle state; called 1 time unit before sampling.
    task automatic run_cmd(input int ack_wait, input int done_wait, input logic [2:0] err,
                           input bit stale, input bit keep);
        int           g;
        logic         e_wr;
        logic [15:0]  e_id;
        logic [31:0]  e_off, e_addr, e_len;
        logic [N-1:0] oh;
        g      = exp_grant();
        oh     = '0;
        oh[g]  = 1'b1;
        e_wr   = req_write[g];
        e_id   = req_id[16*g +: 16];
        e_off  = req_slotoffset[32*g +: 32];
        e_addr = req_bridgeaddr[32*g +: 32];
        e_len  = req_length[32*g +: 32];
        chk("ready_accept", req_ready, oh);
        chk("strobe_idle", {target_dataslot_read, target_dataslot_write}, 2'b00);
        tick();
        if (!keep) begin
            req_valid[g]               = 1'b0;
            req_id[16*g +: 16]         = ~e_id;
            req_slotoffset[32*g +: 32] = ~e_off;
            req_bridgeaddr[32*g +: 32] = ~e_addr;
            req_length[32*g +: 32]     = ~e_len;
        end
        for (int c = 0; c <= ack_wait; c++) begin
            target_dataslot_ack  = (c == ack_wait);
            target_dataslot_done = stale && (c == 0);
            target_dataslot_err  = 3'h5;
            #1;
            chk("read_strobe", target_dataslot_read, !e_wr);
            chk("write_strobe", target_dataslot_write, e_wr);
            chk("busy_issue", busy, 1'b1);
            chk("ready_issue", req_ready, '0);
            chk("done_issue", resp_done, '0);
            if (c == 0) begin
                chk("id_issue", target_dataslot_id, e_id);
                chk("off_issue", target_dataslot_slotoffset, e_off);
                chk("addr_issue", target_dataslot_bridgeaddr, e_addr);
                chk("len_issue", target_dataslot_length, e_len);
            end
            tick();
        end
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b0;
        for (int c = 0; c <= done_wait; c++) begin
            target_dataslot_done = (c == done_wait);
            target_dataslot_err  = (c == done_wait) ? err : 3'($urandom);
            #1;
            chk("strobe_wait", {target_dataslot_read, target_dataslot_write}, 2'b00);
            chk("done_wait", resp_done, '0);
            chk("busy_wait", busy, 1'b1);
            tick();
        end
        target_dataslot_done = 1'b0;
        target_dataslot_err  = ~err;
        #1;
        chk("resp_done", resp_done, oh);
        chk("resp_err", resp_err, err);
        chk("busy_resp", busy, 1'b1);
        chk("id_resp", target_dataslot_id, e_id);
        chk("len_resp", target_dataslot_length, e_len);
        m_rr = (g + 1) % N;
        tick();
        #1;
        chk("done_gap", resp_done, '0);
        chk("busy_gap", busy, 1'b0);
        chk("ready_gap", req_ready, '0);
        chk("strobe_gap", {target_dataslot_read, target_dataslot_write}, 2'b00);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b1;
        req_valid            = 3'b011;
        req_write            = '0;
        req_id               = '0;
        req_slotoffset       = '0;
        req_bridgeaddr       = '0;
        req_length           = '0;
        target_dataslot_ack  = 1'b0;
        target_dataslot_done = 1'b0;
        target_dataslot_err  = 3'h0;
        repeat (3) tick();
        #1;
        chk("rst_ready", req_ready, '0);
        chk("rst_done", resp_done, '0);
        chk("rst_err", resp_err, 3'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {target_dataslot_read, target_dataslot_write}, 2'b00);
        chk("rst_id", target_dataslot_id, 16'h0);
        chk("rst_off", target_dataslot_slotoffset, 32'h0);
        chk("rst_addr", target_dataslot_bridgeaddr, 32'h0);
        chk("rst_len", target_dataslot_length, 32'h0);
        reset     = 1'b0;
        req_valid = '0;
        m_rr      = 0;
        tick();

        // Single read from lane 0
        load_lane(0, 1'b0);
        req_id[15:0]     = 16'h0002;
        req_length[31:0] = 32'h100;
        #1;
        run_cmd(2, 1, 3'h0, 1'b0, 1'b0);

        // Two lanes held: grants alternate
        load_lane(0, 1'b0);
        load_lane(1, 1'b1);
        for (int n = 0; n < 4; n++) begin
            #1;
            run_cmd(0, 0, 3'($urandom), 1'b0, 1'b1);
        end
        req_valid = '0;

        // Stale done before ack
        load_lane(2, 1'b0);
        #1;
        run_cmd(3, 0, 3'h0, 1'b1, 1'b0);

        // Write with error code 2
        load_lane(1, 1'b1);
        #1;
        run_cmd(1, 2, 3'h2, 1'b0, 1'b0);

        // Reset during WAIT_DONE abandons the command
        load_lane(0, 1'b0);
        #1;
        chk("rstmid_ready", req_ready, 3'b001);
        tick();
        req_valid[0]        = 1'b0;
        target_dataslot_ack = 1'b1;
        #1;
        chk("rstmid_read", target_dataslot_read, 1'b1);
        tick();
        target_dataslot_ack = 1'b0;
        #1;
        chk("rstmid_wait_strobe", target_dataslot_read, 1'b0);
        chk("rstmid_wait_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rstmid_strobes", {target_dataslot_read, target_dataslot_write}, 2'b00);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_done", resp_done, '0);
        m_rr = 0;
        tick();
        target_dataslot_done = 1'b1;
        #1;
        chk("rstmid_late_done", resp_done, '0);
        chk("rstmid_idle_busy", busy, 1'b0);
        tick();
        target_dataslot_done = 1'b0;
        load_lane(1, 1'b0);
        load_lane(2, 1'b1);
        #1;
        run_cmd(0, 1, 3'h1, 1'b0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && $urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    load_lane(i, 1'($urandom_range(0, 1)));
                end
            end
            if (req_valid == '0) begin
                load_lane(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
            end
            #1;
            run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 3'($urandom),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
